// File: rtl/wbc_intercon_nxm.sv
// WISHBONE classic NM-master x NS-slave shared bus: registered round-robin grant held for the
// whole master cycle, base/mask slave decode, err for unmapped addresses and stalled slaves.
module wbc_intercon_nxm #(
  parameter int NM = 3,
  parameter int NS = 4,
  parameter int DW = 32,
  parameter int AW = 20,
  parameter int SW = DW / 8,
  parameter logic [NS*AW-1:0] SLV_BASE = {20'h30000, 20'h20000, 20'h10000, 20'h00000},
  parameter logic [NS*AW-1:0] SLV_MASK = {20'h0FFFF, 20'h00FFF, 20'h0FFFF, 20'h0FFFF},
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*DW-1:0] m_dat_i,
  input  logic [NM*SW-1:0] m_sel_i,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NM-1:0]    m_rty_o,
  output logic [DW-1:0]    m_dat_o,
  output logic [NS-1:0]    s_cyc_o,
  output logic [NS-1:0]    s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  output logic [SW-1:0]    s_sel_o,
  input  logic [NS-1:0]    s_ack_i,
  input  logic [NS-1:0]    s_err_i,
  input  logic [NS-1:0]    s_rty_i,
  input  logic [NS*DW-1:0] s_dat_i,
  output logic [NM-1:0]    grant_o,
  output logic             timeout_o
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] last_q, last_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;

  logic          granted;
  logic          gcyc, gstb, we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic [SW-1:0] sel;
  logic [NS-1:0] win;
  logic          hit_any;
  logic [AW-1:0] win_mask;
  logic [DW-1:0] win_dat;
  logic          s_ack_w, s_err_w, s_rty_w, term;
  logic          wdog_force, wdog_fire;
  logic          found;

  assign granted = (state_q == BUSY);

  // Shared request fields follow the granted master, master 0 when the bus is idle.
  always_comb begin
    gcyc = 1'b0;
    gstb = 1'b0;
    adr  = m_adr_i[AW-1:0];
    we   = m_we_i[0];
    wdat = m_dat_i[DW-1:0];
    sel  = m_sel_i[SW-1:0];
    for (int i = 0; i < NM; i++) begin
      if (granted && gidx_q == IW'(i)) begin
        gcyc = m_cyc_i[i];
        gstb = m_stb_i[i];
        adr  = m_adr_i[i*AW +: AW];
        we   = m_we_i[i];
        wdat = m_dat_i[i*DW +: DW];
        sel  = m_sel_i[i*SW +: SW];
      end
    end
  end

  // Lowest-index slave whose base matches the non-offset address bits wins.
  always_comb begin
    hit_any  = 1'b0;
    win      = '0;
    win_mask = '0;
    win_dat  = '0;
    for (int k = 0; k < NS; k++) begin
      if (!hit_any && ((adr & ~SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW])) begin
        hit_any  = 1'b1;
        win[k]   = 1'b1;
        win_mask = SLV_MASK[k*AW +: AW];
        win_dat  = s_dat_i[k*DW +: DW];
      end
    end
  end

  assign s_ack_w = |(s_ack_i & win);
  assign s_err_w = |(s_err_i & win);
  assign s_rty_w = |(s_rty_i & win);
  assign term    = s_ack_w | s_err_w | s_rty_w;

  // The forced drop of cyc/stb does not look at the slave response, so a slave that
  // answers combinationally from stb cannot form a loop through the watchdog.
  assign wdog_force = (wdog_q == WW'(TIMEOUT - 1)) && gstb && hit_any;
  assign wdog_fire  = wdog_force && !term;
  assign timeout_o  = wdog_fire;

  assign s_cyc_o = (gcyc && !wdog_force) ? win : '0;
  assign s_stb_o = (gstb && !wdog_force) ? win : '0;
  assign s_we_o  = we;
  assign s_adr_o = adr & win_mask;
  assign s_dat_o = wdat;
  assign s_sel_o = sel;
  assign m_dat_o = granted ? win_dat : '0;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    grant_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (granted && gidx_q == IW'(i)) begin
        grant_o[i] = 1'b1;
        m_ack_o[i] = s_ack_w;
        m_err_o[i] = s_err_w | err_q | wdog_fire;
        m_rty_o[i] = s_rty_w;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    found   = 1'b0;
    case (state_q)
      IDLE: begin
        // Scan last+1, last+2, ... so the most recent owner has lowest priority.
        for (int d = 1; d <= NM; d++) begin
          for (int j = 0; j < NM; j++) begin
            if (!found && m_cyc_i[j] && ((int'(last_q) + d) % NM) == j) begin
              found   = 1'b1;
              gidx_d  = IW'(j);
              last_d  = IW'(j);
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        if (!gcyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wdog_d = '0;
    if (granted && state_d == BUSY && gstb && hit_any && !term && !wdog_fire)
      wdog_d = wdog_q + 1'b1;
    err_d = (gstb && !hit_any) ? ~err_q : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IW'(NM - 1);
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wbc_intercon_nxm.sv
// Directed scenarios plus random traffic against a cycle-level model of the shared bus.
module tb_wbc_intercon_nxm;
  localparam int NM = 3, NS = 4, DW = 32, AW = 20, SW = 4, TMO = 16;
  localparam logic [NS*AW-1:0] BASE = {20'h30000, 20'h20000, 20'h10000, 20'h00000};
  localparam logic [NS*AW-1:0] MASK = {20'h0FFFF, 20'h00FFF, 20'h0FFFF, 20'h0FFFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NM-1:0] m_cyc, m_stb, m_we, m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*SW-1:0] m_sel;
  logic [DW-1:0] m_dat_o, s_dat_o;
  logic [NS-1:0] s_cyc_o, s_stb_o, s_ack, s_err, s_rty;
  logic s_we_o, timeout_o;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  logic [NS*DW-1:0] s_dat;

  wbc_intercon_nxm #(.NM(NM), .NS(NS), .DW(DW), .AW(AW), .SW(SW),
                     .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_sel_i(m_sel), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .m_dat_o(m_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_ack_i(s_ack),
    .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_dat), .grant_o(grant_o),
    .timeout_o(timeout_o));

  int ncmp = 0, nfail = 0;

  // Model state: current owner (-1 = none), last owner, run of unanswered strobes to a
  // mapped slave, run of strobes to unmapped space.
  int mg, mlast, run, miss_run;
  int d_w;
  bit d_gcyc, d_gstb, d_term, d_force, d_fire;
  logic [AW-1:0] d_adr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int k = 0; k < NS; k++)
      if ((a & ~MASK[k*AW +: AW]) == BASE[k*AW +: AW]) return k;
    return -1;
  endfunction

  function automatic void derive();
    int src;
    src     = (mg >= 0) ? mg : 0;
    d_adr   = m_adr[src*AW +: AW];
    d_w     = decode(d_adr);
    d_gcyc  = (mg >= 0) ? m_cyc[mg] : 1'b0;
    d_gstb  = (mg >= 0) ? m_stb[mg] : 1'b0;
    d_term  = (d_w >= 0) ? (s_ack[d_w] || s_err[d_w] || s_rty[d_w]) : 1'b0;
    d_force = (d_w >= 0) && d_gstb && (run == TMO - 1);
    d_fire  = d_force && !d_term;
  endfunction

  function automatic void model_reset();
    mg = -1; mlast = NM - 1; run = 0; miss_run = 0;
  endfunction

  task automatic check_all();
    logic [NM-1:0] e_gnt, e_ack, e_err, e_rty;
    logic [NS-1:0] e_cyc, e_stb;
    logic [DW-1:0] e_dat;
    derive();
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_cyc = '0; e_stb = '0; e_dat = '0;
    if (mg >= 0) begin
      e_gnt[mg] = 1'b1;
      e_ack[mg] = (d_w >= 0) && s_ack[d_w];
      e_err[mg] = ((d_w >= 0) && s_err[d_w]) || (miss_run % 2 == 1) || d_fire;
      e_rty[mg] = (d_w >= 0) && s_rty[d_w];
      if (d_w >= 0) e_dat = s_dat[d_w*DW +: DW];
    end
    if (d_w >= 0 && !d_force) begin
      e_cyc[d_w] = d_gcyc;
      e_stb[d_w] = d_gstb;
    end
    chk("grant", grant_o, e_gnt);
    chk("s_cyc", s_cyc_o, e_cyc);
    chk("s_stb", s_stb_o, e_stb);
    chk("m_ack", m_ack_o, e_ack);
    chk("m_err", m_err_o, e_err);
    chk("m_rty", m_rty_o, e_rty);
    chk("m_dat", m_dat_o, e_dat);
    chk("timeout", timeout_o, d_fire);
    if (mg >= 0) begin
      chk("s_we", s_we_o, m_we[mg]);
      chk("s_dat", s_dat_o, m_dat[mg*DW +: DW]);
      chk("s_sel", s_sel_o, m_sel[mg*SW +: SW]);
      if (d_w >= 0) chk("s_adr", s_adr_o, d_adr & MASK[d_w*AW +: AW]);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    int nmg, nlast, nrun, nmiss;
    bit found;
    derive();
    nmg = mg; nlast = mlast; found = 0;
    nmiss = (d_gstb && d_w < 0) ? miss_run + 1 : 0;
    nrun  = (d_gstb && d_w >= 0 && !d_term && !d_fire) ? run + 1 : 0;
    if (mg < 0) begin
      for (int d = 1; d <= NM; d++) begin
        if (!found && m_cyc[(mlast + d) % NM]) begin
          found = 1; nmg = (mlast + d) % NM; nlast = nmg;
        end
      end
    end else if (!m_cyc[mg]) nmg = -1;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin mg = nmg; mlast = nlast; run = nrun; miss_run = nmiss; end
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = '0; s_err = '0; s_rty = '0; s_dat = '0;
  endtask

  function automatic logic [AW-1:0] rand_adr();
    logic [AW-1:0] off;
    off = AW'($urandom_range(0, 12'hFFF));
    case ($urandom_range(0, 6))
      0: return 20'h00000 | off;
      1: return 20'h10000 | off;
      2: return 20'h20000 | off;
      3: return 20'h30000 | off;
      4: return 20'hF0000;
      5: return 20'h21000 | off;
      default: return 20'h40004;
    endcase
  endfunction

  logic [NM-1:0] gq[$];
  logic [NM-1:0] prev_g;
  logic [NM-1:0] exp_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int lim;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) begin sample(); tick(); end
    chk("rst_grant", grant_o, 3'b000);
    chk("rst_s_cyc", s_cyc_o, 4'b0000);
    chk("rst_m_ack", m_ack_o, 3'b000);
    chk("rst_timeout", timeout_o, 1'b0);
    rst_n = 1'b1;

    // All masters request; each owner drops cyc once granted.
    prev_g = '0;
    for (int c = 0; c < 14; c++) begin
      m_cyc = 3'b111;
      if (mg >= 0) m_cyc[mg] = 1'b0;
      sample();
      chk("gnt_onehot", $onehot0(grant_o), 1'b1);
      tick();
      if (grant_o != 0 && grant_o != prev_g) gq.push_back(grant_o);
      prev_g = grant_o;
    end
    chk("gnt_order_len", gq.size() >= 4, 1'b1);
    if (gq.size() >= 4)
      for (int i = 0; i < 4; i++) chk("gnt_order", gq[i], exp_order[i]);
    clear_inputs();
    repeat (2) begin sample(); tick(); end

    // M1 write to slave 1.
    m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_adr[AW +: AW] = 20'h10004;
    m_dat[DW +: DW] = 32'hDEADBEEF; m_sel[SW +: SW] = 4'hF;
    sample(); tick();
    s_ack = 4'b0010;
    sample();
    chk("wr_s_cyc", s_cyc_o, 4'b0010);
    chk("wr_s_adr", s_adr_o, 20'h00004);
    chk("wr_s_dat", s_dat_o, 32'hDEADBEEF);
    chk("wr_m_ack", m_ack_o, 3'b010);
    tick();
    clear_inputs();
    repeat (2) begin sample(); tick(); end

    // M0 read from unmapped space.
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0 +: AW] = 20'hF0000;
    s_dat = {4{32'h12345678}};
    sample(); tick();
    sample();
    chk("miss_s_cyc", s_cyc_o, 4'b0000);
    chk("miss_err0", m_err_o, 3'b000);
    tick();
    sample();
    chk("miss_err1", m_err_o, 3'b001);
    chk("miss_dat", m_dat_o, 32'h0);
    tick();
    sample();
    chk("miss_err2", m_err_o, 3'b000);
    tick();
    clear_inputs();
    repeat (2) begin sample(); tick(); end

    // M2 strobes a slave that never answers; second round an ack lands on the deadline.
    m_cyc[2] = 1; m_stb[2] = 1; m_adr[2*AW +: AW] = 20'h30010;
    sample(); tick();
    for (int n = 1; n <= TMO; n++) begin
      sample();
      if (n < TMO) chk("wd_quiet", timeout_o, 1'b0);
      else begin
        chk("wd_timeout", timeout_o, 1'b1);
        chk("wd_err", m_err_o, 3'b100);
        chk("wd_stb_low", s_stb_o, 4'b0000);
      end
      tick();
    end
    for (int n = 1; n <= TMO; n++) begin
      if (n == TMO) s_ack = 4'b1000;
      sample();
      if (n == TMO) begin
        chk("wd_ack_wins", timeout_o, 1'b0);
        chk("wd_ack", m_ack_o, 3'b100);
      end
      tick();
    end
    clear_inputs();
    repeat (2) begin sample(); tick(); end

    // M0 holds its cycle over three strobes while M2 waits.
    m_cyc = 3'b101; m_adr[0 +: AW] = 20'h00100;
    sample(); tick();
    for (int s = 0; s < 3; s++) begin
      m_stb[0] = 1; s_ack = 4'b0001;
      sample();
      chk("hold_gnt", grant_o, 3'b001);
      chk("hold_ack", m_ack_o, 3'b001);
      tick();
      m_stb[0] = 0; s_ack = 4'b0000;
      sample();
      chk("hold_gnt_gap", grant_o, 3'b001);
      tick();
    end
    m_cyc[0] = 0;
    sample(); tick();
    sample();
    chk("hold_idle", grant_o, 3'b000);
    tick();
    sample();
    chk("hold_m2", grant_o, 3'b100);

    // Reset in the middle of an M2 transfer.
    m_stb[2] = 1; m_adr[2*AW +: AW] = 20'h10008;
    tick();
    sample(); tick();
    m_cyc = 3'b111; s_ack = 4'b0010;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_grant", grant_o, 3'b000);
    chk("arst_s_cyc", s_cyc_o, 4'b0000);
    chk("arst_s_stb", s_stb_o, 4'b0000);
    chk("arst_m_ack", m_ack_o, 3'b000);
    sample(); tick();
    rst_n = 1'b1;
    sample(); tick();
    sample();
    chk("arst_first", grant_o, 3'b001);
    tick();
    clear_inputs();
    repeat (2) begin sample(); tick(); end

    // Random traffic: slow slaves first (watchdog active), then responsive ones.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 5) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i] = ($urandom_range(0, 3) != 0);
        m_we[i]  = ($urandom_range(0, 1) != 0);
        m_adr[i*AW +: AW] = rand_adr();
        m_dat[i*DW +: DW] = $urandom;
        m_sel[i*SW +: SW] = SW'($urandom_range(0, 15));
      end
      lim = (c < 700) ? 40 : 5;
      for (int k = 0; k < NS; k++) begin
        s_ack[k] = ($urandom_range(0, lim) == 0);
        s_err[k] = ($urandom_range(0, 4 * lim) == 0);
        s_rty[k] = ($urandom_range(0, 4 * lim) == 0);
        s_dat[k*DW +: DW] = $urandom;
      end
      sample(); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
